// File: rtl/sw_debouncer_pkg.sv
// Shared types and constants for the slide-switch debouncer.
// Holds the FSM state encoding, the board-clock debounce default and a counter-width helper.
package sw_debouncer_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    COUNT = 1'b1
  } deb_state_t;

  // 10 ms worth of cycles at the 100 MHz board clock
  localparam int DEBOUNCE_10MS_100MHZ = 1_000_000;

  function automatic int cnt_width(input int cycles);
    return $clog2(cycles) + 1;
  endfunction

endpackage

// File: rtl/sw_debouncer_sync_2ff.sv
// Two-flop synchroniser for an asynchronous input bus, treated as one vector.
// Reusable for the reset button and other board pins.
module sw_debouncer_sync_2ff #(
  parameter int               WIDTH     = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] sync1_q;
  logic [WIDTH-1:0] sync2_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q <= RESET_VAL;
      sync2_q <= RESET_VAL;
    end else begin
      sync1_q <= d;
      sync2_q <= sync1_q;
    end
  end

  assign q = sync2_q;

endmodule

// File: rtl/sw_debouncer.sv
// Debounces the slide-switch bus: a new synchronised value must hold for STABLE_CYCLES
// consecutive samples before it is committed to sw_db, with a one-cycle sw_changed pulse.
module sw_debouncer
  import sw_debouncer_pkg::*;
#(
  parameter int               WIDTH         = 2,
  parameter int               STABLE_CYCLES = DEBOUNCE_10MS_100MHZ,
  parameter logic [WIDTH-1:0] RESET_VAL     = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] sw_raw,
  output logic [WIDTH-1:0] sw_db,
  output logic             sw_changed,
  output logic             stable
);

  localparam int             CW   = cnt_width(STABLE_CYCLES);
  localparam logic [CW-1:0]  LAST = CW'(STABLE_CYCLES - 1);
  localparam logic [CW-1:0]  ONE  = CW'(1);

  logic [WIDTH-1:0] sync2;

  deb_state_t       state_q,   state_d;
  logic [WIDTH-1:0] cand_q,    cand_d;
  logic [WIDTH-1:0] db_q,      db_d;
  logic [CW-1:0]    cnt_q,     cnt_d;
  logic             changed_q, changed_d;
  logic             stable_q,  stable_d;

  sw_debouncer_sync_2ff #(
    .WIDTH     (WIDTH),
    .RESET_VAL (RESET_VAL)
  ) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (sw_raw),
    .q   (sync2)
  );

  always_comb begin
    state_d   = state_q;
    cand_d    = cand_q;
    db_d      = db_q;
    cnt_d     = cnt_q;
    changed_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (sync2 != db_q) begin
          cand_d  = sync2;
          cnt_d   = ONE;
          state_d = COUNT;
        end else begin
          cnt_d = '0;
        end
      end
      COUNT: begin
        if (sync2 == cand_q) begin
          if (cnt_q == LAST) begin
            db_d      = cand_q;
            changed_d = 1'b1;
            cnt_d     = '0;
            state_d   = IDLE;
          end else begin
            cnt_d = cnt_q + ONE;
          end
        end else if (sync2 == db_q) begin
          // bounced back to the committed value: abandon quietly
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          cand_d = sync2;
          cnt_d  = ONE;
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
    endcase
    stable_d = (state_d == IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      cand_q    <= RESET_VAL;
      db_q      <= RESET_VAL;
      cnt_q     <= '0;
      changed_q <= 1'b0;
      stable_q  <= 1'b1;
    end else begin
      state_q   <= state_d;
      cand_q    <= cand_d;
      db_q      <= db_d;
      cnt_q     <= cnt_d;
      changed_q <= changed_d;
      stable_q  <= stable_d;
    end
  end

  assign sw_db      = db_q;
  assign sw_changed = changed_q;
  assign stable     = stable_q;

endmodule

// File: tb/tb_sw_debouncer.sv
// Directed bench for sw_debouncer with STABLE_CYCLES=8, WIDTH=2, RESET_VAL=0.
module tb_sw_debouncer;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] sw_raw;
  logic [1:0] sw_db;
  logic       sw_changed;
  logic       stable;

  int errors = 0;
  int checks = 0;
  int pulses = 0;

  always #5 clk = ~clk;

  sw_debouncer #(
    .WIDTH         (2),
    .STABLE_CYCLES (8),
    .RESET_VAL     (2'b00)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .sw_raw     (sw_raw),
    .sw_db      (sw_db),
    .sw_changed (sw_changed),
    .stable     (stable)
  );

  // one active edge, then settle; counts sw_changed pulses seen
  task automatic tick();
    @(posedge clk);
    #1;
    if (sw_changed === 1'b1) pulses++;
  endtask

  task automatic settle(input logic [1:0] val);
    sw_raw = val;
    for (int i = 0; i < 14; i++) tick();
    checks++;
    if (sw_db !== val || stable !== 1'b1) begin
      errors++;
      $display("[TB] FAIL settle: sw_db=%b stable=%b required sw_db=%b stable=1", sw_db, stable, val);
    end
  endtask

  task automatic test_reset();
    rst    = 1'b0;
    sw_raw = 2'b11;
    pulses = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if (sw_db !== 2'b00 || sw_changed !== 1'b0 || stable !== 1'b1) begin
        errors++;
        $display("[TB] FAIL reset_hold: sw_db=%b chg=%b stable=%b required 00/0/1", sw_db, sw_changed, stable);
      end
    end
    rst = 1'b1;
    for (int i = 0; i < 9; i++) tick();
    checks++;
    if (sw_db !== 2'b00) begin
      errors++;
      $display("[TB] FAIL reset_early: sw_db=%b required 00 after 9 edges", sw_db);
    end
    tick();
    checks++;
    if (sw_db !== 2'b11 || sw_changed !== 1'b1) begin
      errors++;
      $display("[TB] FAIL reset_commit: sw_db=%b chg=%b required 11/1", sw_db, sw_changed);
    end
    tick();
    checks++;
    if (sw_changed !== 1'b0 || stable !== 1'b1 || pulses != 1) begin
      errors++;
      $display("[TB] FAIL reset_pulse: chg=%b stable=%b pulses=%0d required 0/1/1", sw_changed, stable, pulses);
    end
  endtask

  task automatic test_clean_change();
    settle(2'b00);
    pulses = 0;
    sw_raw = 2'b01;
    tick();
    tick();
    checks++;
    if (stable !== 1'b1) begin
      errors++;
      $display("[TB] FAIL clean_stable_early: stable=%b required 1 after 2 edges", stable);
    end
    tick();
    checks++;
    if (stable !== 1'b0) begin
      errors++;
      $display("[TB] FAIL clean_stable_fall: stable=%b required 0 after 3 edges", stable);
    end
    for (int i = 0; i < 6; i++) tick();
    checks++;
    if (sw_db !== 2'b00 || stable !== 1'b0) begin
      errors++;
      $display("[TB] FAIL clean_early: sw_db=%b stable=%b required 00/0 after 9 edges", sw_db, stable);
    end
    tick();
    checks++;
    if (sw_db !== 2'b01 || sw_changed !== 1'b1) begin
      errors++;
      $display("[TB] FAIL clean_commit: sw_db=%b chg=%b required 01/1", sw_db, sw_changed);
    end
    tick();
    checks++;
    if (sw_changed !== 1'b0 || stable !== 1'b1 || pulses != 1) begin
      errors++;
      $display("[TB] FAIL clean_after: chg=%b stable=%b pulses=%0d required 0/1/1", sw_changed, stable, pulses);
    end
  endtask

  task automatic test_bounce_reject();
    logic bad;
    settle(2'b00);
    pulses = 0;
    bad    = 1'b0;
    for (int i = 0; i < 40; i++) begin
      sw_raw = ((i / 3) % 2 == 1) ? 2'b01 : 2'b00;
      tick();
      if (sw_db !== 2'b00) bad = 1'b1;
    end
    sw_raw = 2'b00;
    for (int i = 0; i < 5; i++) tick();
    checks++;
    if (bad || sw_db !== 2'b00 || pulses != 0) begin
      errors++;
      $display("[TB] FAIL bounce_reject: moved=%b sw_db=%b pulses=%0d required 0/00/0", bad, sw_db, pulses);
    end
    checks++;
    if (stable !== 1'b1) begin
      errors++;
      $display("[TB] FAIL bounce_idle: stable=%b required 1", stable);
    end
  endtask

  task automatic test_bounce_settle();
    pulses = 0;
    for (int i = 0; i < 4; i++) begin
      sw_raw = (i % 2 == 0) ? 2'b10 : 2'b00;
      tick();
    end
    sw_raw = 2'b10;
    for (int i = 0; i < 9; i++) tick();
    checks++;
    if (sw_db !== 2'b00) begin
      errors++;
      $display("[TB] FAIL settle_early: sw_db=%b required 00 after 9 edges", sw_db);
    end
    tick();
    checks++;
    if (sw_db !== 2'b10 || sw_changed !== 1'b1) begin
      errors++;
      $display("[TB] FAIL settle_commit: sw_db=%b chg=%b required 10/1", sw_db, sw_changed);
    end
    for (int i = 0; i < 3; i++) tick();
    checks++;
    if (pulses != 1 || stable !== 1'b1) begin
      errors++;
      $display("[TB] FAIL settle_pulse: pulses=%0d stable=%b required 1/1", pulses, stable);
    end
  endtask

  task automatic test_third_value();
    logic saw01;
    settle(2'b00);
    pulses = 0;
    saw01  = 1'b0;
    sw_raw = 2'b01;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (sw_db === 2'b01) saw01 = 1'b1;
    end
    sw_raw = 2'b11;
    for (int i = 0; i < 9; i++) begin
      tick();
      if (sw_db === 2'b01) saw01 = 1'b1;
    end
    checks++;
    if (sw_db !== 2'b00) begin
      errors++;
      $display("[TB] FAIL third_restart: sw_db=%b required 00 before restarted count ends", sw_db);
    end
    tick();
    checks++;
    if (sw_db !== 2'b11 || sw_changed !== 1'b1) begin
      errors++;
      $display("[TB] FAIL third_commit: sw_db=%b chg=%b required 11/1", sw_db, sw_changed);
    end
    tick();
    tick();
    checks++;
    if (saw01 || pulses != 1) begin
      errors++;
      $display("[TB] FAIL third_pulse: saw01=%b pulses=%0d required 0/1", saw01, pulses);
    end
  endtask

  task automatic test_reset_mid_count();
    settle(2'b00);
    pulses = 0;
    sw_raw = 2'b10;
    for (int i = 0; i < 7; i++) tick();
    checks++;
    if (stable !== 1'b0) begin
      errors++;
      $display("[TB] FAIL midrst_counting: stable=%b required 0", stable);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (sw_db !== 2'b00 || stable !== 1'b1 || sw_changed !== 1'b0) begin
      errors++;
      $display("[TB] FAIL midrst_async: sw_db=%b stable=%b chg=%b required 00/1/0", sw_db, stable, sw_changed);
    end
    tick();
    tick();
    rst = 1'b1;
    for (int i = 0; i < 9; i++) tick();
    checks++;
    if (sw_db !== 2'b00 || pulses != 0) begin
      errors++;
      $display("[TB] FAIL midrst_early: sw_db=%b pulses=%0d required 00/0", sw_db, pulses);
    end
    tick();
    checks++;
    if (sw_db !== 2'b10 || sw_changed !== 1'b1) begin
      errors++;
      $display("[TB] FAIL midrst_commit: sw_db=%b chg=%b required 10/1", sw_db, sw_changed);
    end
  endtask

  initial begin
    rst    = 1'b0;
    sw_raw = 2'b00;
    test_reset();
    test_clean_change();
    test_bounce_reject();
    test_bounce_settle();
    test_third_value();
    test_reset_mid_count();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
